// File: rtl/tx_reset_sm.sv
// Transmit-side reset sequencer for an ECP3 SERDES/PCS quad: quad reset, TX PLL lock wait, PCS release.
// Optional retry limit with a sticky FAULT state is compiled in by defining TX_RST_RETRY_LIMIT_EN.
`timescale 1ns/1ps

module tx_reset_sm #(
  parameter int TIMER1_WIDTH = 2,
  parameter int COUNT_INDEX  = 18,
  parameter int MAX_RETRY    = 7
) (
  input  logic       refclkdiv2,
  input  logic       rst_n,
  input  logic       tx_pll_lol_qd_s,
  input  logic [3:0] chan_en,
  output logic       rst_qd_c,
  output logic [3:0] tx_pcs_rst_ch_c,
  output logic       tx_ready,
  output logic       fault
);

  typedef enum logic [2:0] {
    QUAD_RESET      = 3'd0,
    WAIT_FOR_TIMER1 = 3'd1,
    CHECK_PLOL      = 3'd2,
    WAIT_FOR_TIMER2 = 3'd3,
    NORMAL          = 3'd4
`ifdef TX_RST_RETRY_LIMIT_EN
    ,FAULT          = 3'd5
`endif
  } state_t;

  state_t state, state_next;

  logic                    lol_meta, lol_s;
  logic [TIMER1_WIDTH-1:0] timer1;
  logic                    timer1_done;
  logic [18:0]             timer2;
  logic                    timer2_done;
  logic                    rst_qd_next;
  logic [3:0]              pcs_next;
  logic                    ready_next;

  // Flops reset to "unlocked" so the PLL is never trusted before it has been sampled
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      lol_meta <= 1'b1;
      lol_s    <= 1'b1;
    end else begin
      lol_meta <= tx_pll_lol_qd_s;
      lol_s    <= lol_meta;
    end
  end

  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      timer1      <= '0;
      timer1_done <= 1'b0;
      timer2      <= '0;
      timer2_done <= 1'b0;
    end else begin
      if (state == WAIT_FOR_TIMER1) begin
        if (!timer1[TIMER1_WIDTH-1])
          timer1 <= timer1 + 1'b1;
        timer1_done <= timer1[TIMER1_WIDTH-1];
      end else begin
        timer1      <= '0;
        timer1_done <= 1'b0;
      end
      if (state == WAIT_FOR_TIMER2) begin
        if (!timer2[COUNT_INDEX])
          timer2 <= timer2 + 1'b1;
        timer2_done <= timer2[COUNT_INDEX];
      end else begin
        timer2      <= '0;
        timer2_done <= 1'b0;
      end
    end
  end

`ifdef TX_RST_RETRY_LIMIT_EN
  localparam logic [2:0] RETRY_LAST = 3'(MAX_RETRY - 1);

  logic [2:0] retry_cnt;
  logic       retry_inc;
  logic       retry_clr;
  logic       fault_next;

  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n)
      retry_cnt <= 3'd0;
    else if (retry_clr)
      retry_cnt <= 3'd0;
    else if (retry_inc && retry_cnt != 3'd7)
      retry_cnt <= retry_cnt + 3'd1;
  end
`endif

  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n)
      state <= QUAD_RESET;
    else
      state <= state_next;
  end

  // Loss of lock in NORMAL wins over chan_en, so the PCS resets reassert on the same edge
  always_comb begin
    state_next  = state;
    rst_qd_next = 1'b1;
    pcs_next    = 4'hF;
    ready_next  = 1'b0;
`ifdef TX_RST_RETRY_LIMIT_EN
    fault_next  = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
`endif
    case (state)
      QUAD_RESET: begin
        state_next = WAIT_FOR_TIMER1;
      end
      WAIT_FOR_TIMER1: begin
        if (timer1_done)
          state_next = CHECK_PLOL;
      end
      CHECK_PLOL: begin
        rst_qd_next = 1'b0;
        state_next  = WAIT_FOR_TIMER2;
      end
      WAIT_FOR_TIMER2: begin
        rst_qd_next = 1'b0;
        if (timer2_done) begin
          if (lol_s) begin
`ifdef TX_RST_RETRY_LIMIT_EN
            if (retry_cnt == RETRY_LAST) begin
              state_next = FAULT;
            end else begin
              state_next = QUAD_RESET;
              retry_inc  = 1'b1;
            end
`else
            state_next = QUAD_RESET;
`endif
          end else begin
            state_next = NORMAL;
          end
        end
      end
      NORMAL: begin
        rst_qd_next = 1'b0;
`ifdef TX_RST_RETRY_LIMIT_EN
        retry_clr   = 1'b1;
`endif
        if (lol_s) begin
          state_next = QUAD_RESET;
        end else begin
          pcs_next   = ~chan_en;
          ready_next = 1'b1;
        end
      end
`ifdef TX_RST_RETRY_LIMIT_EN
      FAULT: begin
        rst_qd_next = 1'b0;
        fault_next  = 1'b1;
      end
`endif
      default: begin
        state_next = QUAD_RESET;
      end
    endcase
  end

  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      rst_qd_c        <= 1'b1;
      tx_pcs_rst_ch_c <= 4'hF;
      tx_ready        <= 1'b0;
    end else begin
      rst_qd_c        <= rst_qd_next;
      tx_pcs_rst_ch_c <= pcs_next;
      tx_ready        <= ready_next;
    end
  end

`ifdef TX_RST_RETRY_LIMIT_EN
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n)
      fault <= 1'b0;
    else
      fault <= fault_next;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_tx_reset_sm.sv
// Directed bench for tx_reset_sm with COUNT_INDEX=4, TIMER1_WIDTH=2, MAX_RETRY=3.
// The retry-limit checks follow TX_RST_RETRY_LIMIT_EN, so the bench matches whichever build is compiled.
`timescale 1ns/1ps

module tb_tx_reset_sm;

  logic       refclkdiv2 = 1'b0;
  logic       rst_n;
  logic       tx_pll_lol_qd_s;
  logic [3:0] chan_en;
  logic       rst_qd_c;
  logic [3:0] tx_pcs_rst_ch_c;
  logic       tx_ready;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 refclkdiv2 = ~refclkdiv2;

  tx_reset_sm #(
    .TIMER1_WIDTH(2),
    .COUNT_INDEX (4),
    .MAX_RETRY   (3)
  ) dut (
    .refclkdiv2     (refclkdiv2),
    .rst_n          (rst_n),
    .tx_pll_lol_qd_s(tx_pll_lol_qd_s),
    .chan_en        (chan_en),
    .rst_qd_c       (rst_qd_c),
    .tx_pcs_rst_ch_c(tx_pcs_rst_ch_c),
    .tx_ready       (tx_ready),
    .fault          (fault)
  );

  // Advance n rising edges, landing on the following falling edge
  task automatic step(input int n);
    repeat (n) @(negedge refclkdiv2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int qd_hi;
    int rdy_hi;
    rst_n           = 1'b0;
    tx_pll_lol_qd_s = 1'b0;
    chan_en         = 4'hF;
    step(3);
    check("reset_qd", 32'(rst_qd_c), 32'd1);
    check("reset_pcs", 32'(tx_pcs_rst_ch_c), 32'hF);
    check("reset_ready", 32'(tx_ready), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);

    // Power-up sequence: edges are counted from the rst_n release
    rst_n = 1'b1;
    step(5);
    check("seq_qd_c5", 32'(rst_qd_c), 32'd1);
    step(1);
    check("seq_qd_c6", 32'(rst_qd_c), 32'd0);
    check("seq_pcs_c6", 32'(tx_pcs_rst_ch_c), 32'hF);
    step(18);
    check("seq_ready_c24", 32'(tx_ready), 32'd0);
    check("seq_pcs_c24", 32'(tx_pcs_rst_ch_c), 32'hF);
    step(1);
    check("seq_ready_c25", 32'(tx_ready), 32'd1);
    check("seq_pcs_c25", 32'(tx_pcs_rst_ch_c), 32'h0);

    chan_en = 4'b0011;
    step(1);
    check("chan_0011", 32'(tx_pcs_rst_ch_c), 32'hC);
    chan_en = 4'b1011;
    check("chan_bit3_lag", 32'(tx_pcs_rst_ch_c), 32'hC);
    step(1);
    check("chan_1011", 32'(tx_pcs_rst_ch_c), 32'h4);
    chan_en = 4'hF;
    step(1);
    check("chan_restore", 32'(tx_pcs_rst_ch_c), 32'h0);

    // Three-cycle loss-of-lock pulse: restart at edge 3, NORMAL again at edge 27
    tx_pll_lol_qd_s = 1'b1;
    step(3);
    tx_pll_lol_qd_s = 1'b0;
    step(1);
    check("lolp_ready_e4", 32'(tx_ready), 32'd0);
    check("lolp_pcs_e4", 32'(tx_pcs_rst_ch_c), 32'hF);
    check("lolp_qd_e4", 32'(rst_qd_c), 32'd1);
    step(23);
    check("lolp_ready_e27", 32'(tx_ready), 32'd0);
    step(1);
    check("lolp_ready_e28", 32'(tx_ready), 32'd1);

    // Held loss of lock: 5-cycle quad-reset pulses every 24 cycles
    tx_pll_lol_qd_s = 1'b1;
    step(3);
    qd_hi  = 0;
    rdy_hi = 0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      qd_hi  += int'(rst_qd_c);
      rdy_hi += int'(tx_ready);
    end
    check("lolh_qd_cycles", 32'(qd_hi), 32'd10);
    check("lolh_ready_cycles", 32'(rdy_hi), 32'd0);
    check("lolh_fault_e51", 32'(fault), 32'd0);
    step(29);
`ifdef TX_RST_RETRY_LIMIT_EN
    check("retry_fault_set", 32'(fault), 32'd1);
    check("retry_fault_qd", 32'(rst_qd_c), 32'd0);
    check("retry_fault_pcs", 32'(tx_pcs_rst_ch_c), 32'hF);
    qd_hi = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      qd_hi += int'(rst_qd_c);
    end
    check("retry_no_more_pulses", 32'(qd_hi), 32'd0);
    check("retry_fault_sticky", 32'(fault), 32'd1);
`else
    check("unlimited_fault", 32'(fault), 32'd0);
    check("unlimited_ready", 32'(tx_ready), 32'd0);
`endif

    tx_pll_lol_qd_s = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_clears_fault", 32'(fault), 32'd0);
    check("rst_async_qd", 32'(rst_qd_c), 32'd1);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("mid_t2_qd", 32'(rst_qd_c), 32'd0);

    // Asynchronous reset in the middle of the PLL-lock wait
    rst_n = 1'b0;
    #1;
    check("mid_rst_qd", 32'(rst_qd_c), 32'd1);
    check("mid_rst_pcs", 32'(tx_pcs_rst_ch_c), 32'hF);
    check("mid_rst_ready", 32'(tx_ready), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check("reseq_qd_c5", 32'(rst_qd_c), 32'd1);
    step(1);
    check("reseq_qd_c6", 32'(rst_qd_c), 32'd0);
    step(18);
    check("reseq_ready_c24", 32'(tx_ready), 32'd0);
    step(1);
    check("reseq_ready_c25", 32'(tx_ready), 32'd1);
    check("reseq_pcs_c25", 32'(tx_pcs_rst_ch_c), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
